// File: rtl/vip_stream_input_skid_if.sv
// Avalon-ST handshake bundle for the VIP stream input stage.
// Holds the upstream (din_*) and downstream (int_*) beat signals.
//   slave  : the input stage (accepts din_*, produces int_*, drives din_ready)
//   master : the surrounding logic (produces din_*, consumes int_*, drives int_ready)
interface vip_stream_input_skid_if #(
  parameter int unsigned W = 30
) ();
  logic         din_ready;
  logic         din_valid;
  logic [W-1:0] din_data;
  logic         din_sop;
  logic         din_eop;
  logic         int_ready;
  logic         int_valid;
  logic [W-1:0] int_data;
  logic         int_sop;
  logic         int_eop;

  modport slave (
    output din_ready,
    input  din_valid, din_data, din_sop, din_eop,
    input  int_ready,
    output int_valid, int_data, int_sop, int_eop
  );

  modport master (
    input  din_ready,
    output din_valid, din_data, din_sop, din_eop,
    output int_ready,
    input  int_valid, int_data, int_sop, int_eop
  );
endinterface

// File: rtl/vip_stream_input_skid.sv
// Avalon-ST input stage for the VIP frame path.
// Registers din_ready and absorbs in-flight beats for a ready latency of
// 1..4 using a credit-counted skid FIFO of depth READY_LATENCY+2.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     din_* upstream beat (ready latency L), int_* downstream
//                   beat (ready latency 0, first-word fall-through)
//   resync          pulse: re-enter drop-until-SOP (when SYNC_TO_SOP=1)
//   err_protocol    sticky: din_valid seen without a grant
//   err_missing_eop one-cycle pulse: SOP accepted while a packet was open
//   pkt_count       EOP beats delivered downstream, wraps at 16 bits
module vip_stream_input_skid #(
  parameter int unsigned BITS_PER_SYMBOL  = 10,
  parameter int unsigned SYMBOLS_PER_BEAT = 3,
  parameter int unsigned READY_LATENCY    = 1,
  parameter int unsigned SYNC_TO_SOP      = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vip_stream_input_skid_if.slave   bus,
  input  logic                     resync,
  output logic                     err_protocol,
  output logic                     err_missing_eop,
  output logic [15:0]              pkt_count
);

  localparam int unsigned W  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int unsigned L  = READY_LATENCY;
  localparam int unsigned D  = L + 2;
  localparam int unsigned PW = $clog2(D);
  localparam int unsigned CW = $clog2(D + 1);

  typedef struct packed {
    logic [W-1:0] data;
    logic         sop;
    logic         eop;
  } beat_t;

  typedef enum logic {ST_SYNC, ST_PASS} state_t;

  beat_t          mem [D];
  beat_t          head;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  fill;
  logic [L-1:0]   g;
  logic           din_ready_r;
  state_t         state;
  logic           pkt_open;

  logic           granted;
  logic           accept;
  logic           pop;
  logic [CW-1:0]  fill_next;
  logic [L-1:0]   g_next;
  logic           ready_next;
  int unsigned    pend_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == D - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    granted   = bus.din_valid & g[L-1];
    // With SYNC_TO_SOP=0 the state never leaves PASS, so this covers both modes.
    accept    = granted & ((state == ST_PASS) | bus.din_sop);
    pop       = (fill != '0) & bus.int_ready;
    fill_next = fill;
    if (accept && !pop) begin
      fill_next = fill + 1'b1;
    end else if (!accept && pop) begin
      fill_next = fill - 1'b1;
    end
    g_next   = (g << 1) | L'(din_ready_r);
    // Grants already issued whose beats can still arrive from next cycle on:
    // the current ready plus the youngest L-1 history bits.
    pend_cnt = 32'(din_ready_r);
    for (int unsigned i = 0; i + 1 < L; i++) begin
      pend_cnt += 32'(g[i]);
    end
    ready_next = (32'(fill_next) + pend_cnt) < D;
  end

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill            <= '0;
      g               <= '0;
      din_ready_r     <= 1'b0;
      state           <= (SYNC_TO_SOP != 0) ? ST_SYNC : ST_PASS;
      pkt_open        <= 1'b0;
      err_protocol    <= 1'b0;
      err_missing_eop <= 1'b0;
      pkt_count       <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        mem[i] <= '0;
      end
    end else begin
      g           <= g_next;
      din_ready_r <= ready_next;
      fill        <= fill_next;

      if (accept) begin
        mem[wr_ptr] <= '{data: bus.din_data, sop: bus.din_sop, eop: bus.din_eop};
        wr_ptr      <= ptr_inc(wr_ptr);
        if (bus.din_eop) begin
          pkt_open <= 1'b0;
        end else if (bus.din_sop) begin
          pkt_open <= 1'b1;
        end
      end

      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        if (head.eop) begin
          pkt_count <= pkt_count + 1'b1;
        end
      end

      if (bus.din_valid && !g[L-1]) begin
        err_protocol <= 1'b1;
      end
      err_missing_eop <= accept & bus.din_sop & pkt_open;

      // A beat on the resync cycle was already judged against PASS above.
      if (SYNC_TO_SOP != 0) begin
        if (resync) begin
          state <= ST_SYNC;
        end else if (state == ST_SYNC && granted && bus.din_sop) begin
          state <= ST_PASS;
        end
      end
    end
  end

  assign bus.din_ready = din_ready_r;
  assign bus.int_valid = (fill != '0);
  assign bus.int_data  = head.data;
  assign bus.int_sop   = head.sop;
  assign bus.int_eop   = head.eop;

endmodule
